// File: rtl/a2_bridge_sequencer.sv
// a2_bridge_sequencer
//   Owns the shared A2 bridge port (sel/rd/wr/d_o/d_oe/d_i). Runs the
//   post-reset GPIO init write, polls the control byte (sel 0) while idle,
//   and arbitrates single-byte bridge transactions between NUM_REQ requesters
//   (fixed priority, index 0 highest, optional lock for back-to-back bytes).
//
// Ports
//   clk_logic, device_reset       clock, async active-high reset
//   req_i/lock_i/we_i [NUM_REQ]   per-channel request, lock, direction (1=write)
//   sel_i [2*NUM_REQ]             per-channel bridge select
//   wdata_i [8*NUM_REQ]           per-channel write byte
//   gnt_o/done_o [NUM_REQ]        one-hot accept / completion pulses
//   rdata_o [8]                   last read byte (held)
//   ctrl_in_o, ctrl_in_valid_o    last polled control byte + update pulse
//   busy_o, init_done_o           not-IDLE flag, init write completed
//   a2_bridge_*                   registered bridge pins, d_i bridge read data
module a2_bridge_sequencer #(
  parameter int unsigned NUM_REQ    = 4,
  parameter logic [7:0]  INIT_VALUE = 8'hFF
) (
  input  logic                 clk_logic,
  input  logic                 device_reset,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [NUM_REQ-1:0]   lock_i,
  input  logic [2*NUM_REQ-1:0] sel_i,
  input  logic [NUM_REQ-1:0]   we_i,
  input  logic [8*NUM_REQ-1:0] wdata_i,
  output logic [NUM_REQ-1:0]   gnt_o,
  output logic [NUM_REQ-1:0]   done_o,
  output logic [7:0]           rdata_o,
  output logic [7:0]           ctrl_in_o,
  output logic                 ctrl_in_valid_o,
  output logic                 busy_o,
  output logic                 init_done_o,
  output logic [1:0]           a2_bridge_sel_o,
  output logic                 a2_bridge_rd_o,
  output logic                 a2_bridge_wr_o,
  output logic [7:0]           a2_bridge_d_o,
  output logic                 a2_bridge_d_oe_o,
  input  logic [7:0]           a2_bridge_d_i
);

  localparam int unsigned IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [3:0] {
    INIT0, INIT1, INIT2, IDLE, RD0, RD1, WR0, WR1, WR2
  } state_e;

  state_e              state_q, state_d;
  logic [IDXW-1:0]     ch_q, ch_d;
  logic [1:0]          csel_q, csel_d;
  logic [7:0]          cwdata_q, cwdata_d;

  logic                win_found;
  logic [IDXW-1:0]     win_idx;
  logic                start, finish;
  logic [IDXW-1:0]     start_idx;
  logic [NUM_REQ-1:0]  gnt_d, done_d;

  logic [1:0]          sel_q, sel_d;
  logic                rd_q, rd_d, wr_q, wr_d, oe_q, oe_d;
  logic [7:0]          dout_q, dout_d;
  logic [7:0]          rdata_q, ctrl_q;
  logic                ctrl_v_q, init_done_q;
  logic [NUM_REQ-1:0]  gnt_q, done_q;

  // Fixed-priority pick: lowest requesting index.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_i[i] && !win_found) begin
        win_found = 1'b1;
        win_idx   = IDXW'(i);
      end
    end
  end

  // Next state. A locked channel re-enters RD0/WR0 directly from RD1/WR2 and
  // recaptures its select/data there, so nobody else can slip in between.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    csel_d    = csel_q;
    cwdata_d  = cwdata_q;
    start     = 1'b0;
    finish    = 1'b0;
    start_idx = ch_q;
    case (state_q)
      INIT0: state_d = INIT1;
      INIT1: state_d = INIT2;
      INIT2: state_d = IDLE;
      IDLE: begin
        if (win_found) begin
          start     = 1'b1;
          start_idx = win_idx;
        end
      end
      RD0:   state_d = RD1;
      WR0:   state_d = WR1;
      WR1:   state_d = WR2;
      RD1, WR2: begin
        finish = 1'b1;
        if (lock_i[ch_q] && req_i[ch_q]) start = 1'b1;
        else                             state_d = IDLE;
      end
      default: state_d = INIT0;
    endcase
    if (start) begin
      ch_d     = start_idx;
      csel_d   = sel_i[32'(start_idx)*2 +: 2];
      cwdata_d = wdata_i[32'(start_idx)*8 +: 8];
      state_d  = we_i[start_idx] ? WR0 : RD0;
    end
  end

  // Bridge pin values for the state being entered, so the registered pins
  // line up with the state they belong to.
  always_comb begin
    sel_d  = 2'b00;
    rd_d   = 1'b0;
    wr_d   = 1'b0;
    oe_d   = 1'b0;
    dout_d = dout_q;
    gnt_d  = '0;
    done_d = '0;
    case (state_d)
      INIT0: begin dout_d = INIT_VALUE; oe_d = 1'b1; end
      INIT1: begin dout_d = INIT_VALUE; oe_d = 1'b1; wr_d = 1'b1; end
      IDLE:  rd_d = 1'b1;
      RD0, RD1: begin sel_d = csel_d; rd_d = 1'b1; end
      WR0: begin sel_d = csel_d; dout_d = cwdata_d; oe_d = 1'b1; end
      WR1: begin sel_d = csel_d; dout_d = cwdata_d; oe_d = 1'b1; wr_d = 1'b1; end
      default: ;
    endcase
    if (start)  gnt_d[start_idx] = 1'b1;
    if (finish) done_d[ch_q]     = 1'b1;
  end

  always_ff @(posedge clk_logic or posedge device_reset) begin
    if (device_reset) begin
      state_q     <= INIT0;
      ch_q        <= '0;
      csel_q      <= '0;
      cwdata_q    <= '0;
      sel_q       <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      oe_q        <= 1'b0;
      dout_q      <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      rdata_q     <= '0;
      ctrl_q      <= '1;
      ctrl_v_q    <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      csel_q   <= csel_d;
      cwdata_q <= cwdata_d;
      sel_q    <= sel_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      oe_q     <= oe_d;
      dout_q   <= dout_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      if (state_q == RD1) rdata_q <= a2_bridge_d_i;
      // Poll only when rd has already been high for a full idle cycle.
      ctrl_v_q <= (state_q == IDLE) && (state_d == IDLE);
      if ((state_q == IDLE) && (state_d == IDLE)) ctrl_q <= a2_bridge_d_i;
      if (state_q == INIT2) init_done_q <= 1'b1;
    end
  end

  assign gnt_o            = gnt_q;
  assign done_o           = done_q;
  assign rdata_o          = rdata_q;
  assign ctrl_in_o        = ctrl_q;
  assign ctrl_in_valid_o  = ctrl_v_q;
  assign busy_o           = (state_q != IDLE);
  assign init_done_o      = init_done_q;
  assign a2_bridge_sel_o  = sel_q;
  assign a2_bridge_rd_o   = rd_q;
  assign a2_bridge_wr_o   = wr_q;
  assign a2_bridge_d_o    = dout_q;
  assign a2_bridge_d_oe_o = oe_q;

endmodule
